metric_pingpong_mem: RTL and testbench

- Parametrised ping-pong path-metric store for the Viterbi ACS array.
- Each cycle the ACS writes N_ACS new metrics into the current write bank. The read port serves adjacent word pairs from the opposite bank.
- Next generation of the fixed 64-entry metric memory. Added over that block:
  - internal write-address counter and automatic bank swap at the end of each trellis step;
  - registered read with a valid flag;
  - MSB-based metric normalization;
  - synchronous pass restart.

---
 rtl/metric_pingpong_mem_pkg.sv | 19 +
 rtl/metric_norm_mask.sv | 23 ++
 rtl/metric_pingpong_mem.sv | 111 +++++++++++
 tb/tb_metric_pingpong_mem.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/metric_pingpong_mem_pkg.sv
// Shared parameters for the ping-pong path-metric store: default geometry
// and the address-width helper used to derive pointer sizes.
package metric_pingpong_mem_pkg;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  localparam int DEF_WD_METR  = 8;
  localparam int DEF_N_ACS    = 4;
  localparam int DEF_N_STATE  = 256;
  localparam int DEF_N_ITER   = DEF_N_STATE / DEF_N_ACS;
  localparam int DEF_WD_WA    = clog2(DEF_N_ITER);
  localparam int DEF_WD_RA    = DEF_WD_WA - 1;

endpackage

// File: rtl/metric_norm_mask.sv
// Per-field MSB inspection over a packed vector of metrics: reports whether
// every field has its MSB set and produces a copy with all field MSBs cleared.
module metric_norm_mask #(
  parameter int WD_METR = 8,
  parameter int N_FIELD = 4
) (
  input  logic [WD_METR*N_FIELD-1:0] data,
  output logic                       all_msb,
  output logic [WD_METR*N_FIELD-1:0] cleared
);

  // NOTE: every output gets a default before the loop, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    all_msb = 1'b1;
    cleared = data;
    for (int i = 0; i < N_FIELD; i++) begin
      all_msb                        = all_msb & data[i*WD_METR + WD_METR - 1];
      cleared[i*WD_METR + WD_METR - 1] = 1'b0;
    end
  end

endmodule

// File: rtl/metric_pingpong_mem.sv
// Ping-pong path-metric store: the ACS fills one bank word by word while the
// traceback side reads word pairs from the other; banks swap each trellis step.
module metric_pingpong_mem
  import metric_pingpong_mem_pkg::*;
#(
  parameter int WD_METR = DEF_WD_METR,
  parameter int N_ACS   = DEF_N_ACS,
  parameter int N_STATE = DEF_N_STATE,
  parameter int WD_WA   = clog2(N_STATE / N_ACS),
  parameter int WD_RA   = WD_WA - 1
) (
  input  logic                         Clock1,
  input  logic                         Reset,
  input  logic                         Restart,
  input  logic                         Active,
  input  logic [WD_METR*N_ACS-1:0]     MMMetric,
  input  logic                         MMReadEn,
  input  logic [WD_RA-1:0]             MMReadAddress,
  output logic [2*WD_METR*N_ACS-1:0]   MMPathMetric,
  output logic                         MMReadValid,
  output logic                         MMBlockSelect,
  output logic                         StepDone,
  output logic                         NormActive
);

  localparam int N_ITER  = N_STATE / N_ACS;
  localparam int WD_WORD = WD_METR * N_ACS;

  logic [WD_WORD-1:0]   bank [2][N_ITER];
  logic [WD_WA-1:0]     wr_ptr;
  logic                 all_msb;
  logic                 last_word;

  logic                 metric_all_msb;
  logic [WD_WORD-1:0]   unused_metric_cleared;

  logic                 rd_bank;
  logic [WD_WA-1:0]     rd_lo;
  logic [WD_WA-1:0]     rd_hi;
  logic [2*WD_WORD-1:0] rd_pair;
  logic [2*WD_WORD-1:0] rd_pair_norm;
  logic                 unused_rd_all_msb;

  metric_norm_mask #(.WD_METR(WD_METR), .N_FIELD(N_ACS)) u_wr_mask (
    .data    (MMMetric),
    .all_msb (metric_all_msb),
    .cleared (unused_metric_cleared)
  );

  metric_norm_mask #(.WD_METR(WD_METR), .N_FIELD(2*N_ACS)) u_rd_mask (
    .data    (rd_pair),
    .all_msb (unused_rd_all_msb),
    .cleared (rd_pair_norm)
  );

  assign last_word = (wr_ptr == WD_WA'(N_ITER - 1));
  assign rd_bank   = ~MMBlockSelect;
  assign rd_lo     = {MMReadAddress, 1'b0};
  assign rd_hi     = {MMReadAddress, 1'b1};
  assign rd_pair   = {bank[rd_bank][rd_hi], bank[rd_bank][rd_lo]};

  // NOTE: the banks sit in the async reset domain because a cleared metric
  // store is part of the reset state; this keeps them in flops, not RAM macros.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(negedge Clock1 or negedge Reset) begin
    if (!Reset) begin
      wr_ptr        <= '0;
      all_msb       <= 1'b1;
      MMBlockSelect <= 1'b0;
      StepDone      <= 1'b0;
      NormActive    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_ITER; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else begin
      StepDone <= 1'b0;
      if (Restart) begin
        wr_ptr  <= '0;
        all_msb <= 1'b1;
      end else if (Active) begin
        bank[MMBlockSelect][wr_ptr] <= MMMetric;
        wr_ptr                      <= wr_ptr + 1'b1;
        if (last_word) begin
          // The word written on this edge still counts towards the step's verdict.
          MMBlockSelect <= ~MMBlockSelect;
          NormActive    <= all_msb & metric_all_msb;
          all_msb       <= 1'b1;
          StepDone      <= 1'b1;
        end else begin
          all_msb <= all_msb & metric_all_msb;
        end
      end
    end
  end

  always_ff @(negedge Clock1 or negedge Reset) begin
    if (!Reset) begin
      MMPathMetric <= '0;
      MMReadValid  <= 1'b0;
    end else begin
      MMReadValid <= MMReadEn;
      if (MMReadEn) begin
        MMPathMetric <= NormActive ? rd_pair_norm : rd_pair;
      end
    end
  end

endmodule

// File: tb/tb_metric_pingpong_mem.sv
// Randomized and directed bench for metric_pingpong_mem against a word-level
// reference model of the two banks, the step counter and the normalization flag.
module tb_metric_pingpong_mem;

  logic        Clock1 = 1'b0;
  logic        Reset = 1'b0;
  logic        Restart = 1'b0;
  logic        Active = 1'b0;
  logic [31:0] MMMetric = '0;
  logic        MMReadEn = 1'b0;
  logic [4:0]  MMReadAddress = '0;
  logic [63:0] MMPathMetric;
  logic        MMReadValid;
  logic        MMBlockSelect;
  logic        StepDone;
  logic        NormActive;

  int n_cmp = 0;
  int n_bad = 0;
  string phase = "init";

  logic [31:0] mb [2][64];
  int          mptr;
  bit          msel, mnorm, mall, mstep, mvalid;
  logic [63:0] mpd;
  logic [31:0] pass_words [64];

  metric_pingpong_mem dut (
    .Clock1        (Clock1),
    .Reset         (Reset),
    .Restart       (Restart),
    .Active        (Active),
    .MMMetric      (MMMetric),
    .MMReadEn      (MMReadEn),
    .MMReadAddress (MMReadAddress),
    .MMPathMetric  (MMPathMetric),
    .MMReadValid   (MMReadValid),
    .MMBlockSelect (MMBlockSelect),
    .StepDone      (StepDone),
    .NormActive    (NormActive)
  );

  always #5 Clock1 = ~Clock1;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("FAIL %s/%s: observed %h expected %h", phase, tag, observed, expected);
    end
  endtask

  function automatic bit fields_high(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      if (w[8*i + 7] == 1'b0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] norm_word(input logic [31:0] w, input bit n);
    logic [31:0] o;
    o = w;
    if (n) begin
      for (int i = 0; i < 4; i++) begin
        if (o[8*i + 7]) o[8*i +: 8] = o[8*i +: 8] - 8'd128;
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] high_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'($urandom_range(128, 192));
    return w;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 64; i++) mb[b][i] = '0;
    mptr = 0; msel = 0; mnorm = 0; mall = 1; mstep = 0; mvalid = 0; mpd = '0;
  endtask

  // One falling edge: model predicts, DUT steps, all outputs are compared.
  task automatic cycle(input bit act, input logic [31:0] m, input bit ren,
                       input logic [4:0] r, input bit rs);
    Active = act; MMMetric = m; MMReadEn = ren; MMReadAddress = r; Restart = rs;
    mvalid = ren;
    if (ren) mpd = {norm_word(mb[!msel][2*r + 1], mnorm), norm_word(mb[!msel][2*r], mnorm)};
    mstep = 0;
    if (rs) begin
      mptr = 0; mall = 1;
    end else if (act) begin
      mb[msel][mptr] = m;
      mall = mall && fields_high(m);
      mptr++;
      if (mptr == 64) begin
        mptr = 0; msel = !msel; mnorm = mall; mall = 1; mstep = 1;
      end
    end
    @(negedge Clock1);
    #1;
    check("valid", 64'(MMReadValid), 64'(mvalid));
    check("rdata", MMPathMetric, mpd);
    check("bank_sel", 64'(MMBlockSelect), 64'(msel));
    check("step_done", 64'(StepDone), 64'(mstep));
    check("norm", 64'(NormActive), 64'(mnorm));
  endtask

  initial begin
    logic [4:0] r6;

    model_reset();
    phase = "por";
    repeat (2) @(negedge Clock1);
    #1;
    check("rdata", MMPathMetric, 64'h0);
    check("valid", 64'(MMReadValid), 64'h0);
    check("bank_sel", 64'(MMBlockSelect), 64'h0);
    check("step_done", 64'(StepDone), 64'h0);
    check("norm", 64'(NormActive), 64'h0);
    #2 Reset = 1'b1;

    phase = "count";
    for (int k = 0; k < 64; k++) cycle(1, {4{8'(k)}}, 0, 0, 0);
    check("pulse_hi", 64'(StepDone), 64'h1);
    check("sel_after", 64'(MMBlockSelect), 64'h1);
    cycle(0, 0, 1, 5'd3, 0);
    check("pair_r3", MMPathMetric, 64'h07070707_06060606);
    check("valid_r3", 64'(MMReadValid), 64'h1);
    check("pulse_lo", 64'(StepDone), 64'h0);

    phase = "norm_on";
    for (int k = 0; k < 64; k++) cycle(1, (k == 10) ? 32'h85858585 : high_word(), 0, 0, 0);
    check("norm_flag", 64'(NormActive), 64'h1);
    cycle(0, 0, 1, 5'd5, 0);
    check("low_half", 64'(MMPathMetric[31:0]), 64'h05050505);

    phase = "norm_off";
    for (int k = 0; k < 64; k++) begin
      logic [31:0] w;
      w = (k == 10) ? 32'h85858585 : high_word();
      if (k == 40) w[7:0] = 8'h7F;
      cycle(1, w, 0, 0, 0);
    end
    check("norm_flag", 64'(NormActive), 64'h0);
    cycle(0, 0, 1, 5'd5, 0);
    check("low_half", 64'(MMPathMetric[31:0]), 64'h85858585);

    phase = "restart";
    for (int k = 0; k < 20; k++) cycle(1, $urandom, 0, 0, 0);
    cycle(1, $urandom, 0, 0, 1);
    check("no_pulse", 64'(StepDone), 64'h0);
    check("no_swap", 64'(MMBlockSelect), 64'h1);
    for (int k = 0; k < 63; k++) cycle(1, $urandom, 0, 0, 0);
    check("early_sel", 64'(MMBlockSelect), 64'h1);
    cycle(1, $urandom, 0, 0, 0);
    check("swap_64th", 64'(MMBlockSelect), 64'h0);
    check("pulse_64th", 64'(StepDone), 64'h1);

    phase = "swap_read";
    r6 = 5'($urandom_range(0, 31));
    for (int k = 0; k < 64; k++) pass_words[k] = (k == 0) ? 32'h0 : $urandom;
    for (int k = 0; k < 63; k++) cycle(1, pass_words[k], 0, 0, 0);
    cycle(1, pass_words[63], 1, r6, 0);
    cycle(0, 0, 1, r6, 0);
    check("fresh_pair", MMPathMetric, {pass_words[2*r6 + 1], pass_words[2*r6]});

    phase = "random";
    for (int k = 0; k < 600; k++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 7) == 0) ? $urandom : high_word();
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), $urandom_range(0, 199) == 0);
    end

    phase = "mid_reset";
    cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 17; k++) cycle(1, 32'hFFFF_FFFF - k, 1, 5'($urandom_range(0, 31)), 0);
    #2 Reset = 1'b0;
    #1;
    check("rdata", MMPathMetric, 64'h0);
    check("bank_sel", 64'(MMBlockSelect), 64'h0);
    check("step_done", 64'(StepDone), 64'h0);
    check("norm", 64'(NormActive), 64'h0);
    check("valid", 64'(MMReadValid), 64'h0);
    model_reset();
    @(negedge Clock1);
    #2 Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 1, 5'($urandom_range(0, 31)), 0);
      check("cleared", MMPathMetric, 64'h0);
    end
    for (int k = 0; k < 64; k++) cycle(1, high_word(), k[0], 5'($urandom_range(0, 31)), 0);
    check("pulse_after", 64'(StepDone), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
